sdram_rq_arbiter: RTL and testbench
===================================

// Module: sdram_rq_arbiter
// PURPOSE
// - Shares the single emulator SDRAM read port between the MAINCPU program ROM and OBJROM requesters.
// - Each requester keeps its existing interface: address bus, active-low request strobe, and an 8-bit data return.
// - One-entry hit cache per requester suppresses repeat fetches of the same address.
// - Fixed OBJ priority with a CPU starvation guard; sits between the game core and the SDRAM controller.
// PARAMETERS
// - ADDR_W      17          requester address width
// - SD_AW       24          SDRAM byte address width
// - CPU_BASE    24'h000000  SDRAM base of MAINCPU region
// - OBJ_BASE    24'h020000  SDRAM base of OBJROM region
// - OBJ_MAXRUN  4           consecutive OBJ grants allowed while CPU is pending (1..15)
// PORTS
// - i_EMU_MCLK          in   1        master clock, all logic on rising edge
// - i_EMU_INITRST_n     in   1        asynchronous active-low reset
// - i_CPU_ADDR          in   ADDR_W   MAINCPU address
// - i_CPU_RQ_n          in   1        MAINCPU request, level, active low
// - o_CPU_DATA          out  8        MAINCPU data, held until next fill
// - o_CPU_RDY           out  1        o_CPU_DATA valid for the current i_CPU_ADDR
// - i_OBJ_ADDR/i_OBJ_RQ_n/o_OBJ_DATA/o_OBJ_RDY   same set for OBJROM
// - o_SD_ADDR           out  SD_AW    SDRAM read address
// - o_SD_RD             out  1        read command, held until acked
// - i_SD_ACK            in   1        1-cycle command accept
// - i_SD_DVALID         in   1        1-cycle read data strobe
// - i_SD_DATA           in   8        read data
// BEHAVIOUR
// - Reset: all outputs 0; caches invalid; FSM IDLE; run counter 0.
// - Per-port miss = RQ_n==0 AND (cache invalid OR ADDR != cached addr).
// - Per-port hit  = RQ_n==0 AND valid AND ADDR == cached addr.
// - RDY is a registered copy of hit: it rises 1 cycle after the address matches and falls 1 cycle after a mismatch or RQ_n=1.
// - FSM IDLE
//   - No miss: stay IDLE.
//   - Any miss: grant one port, latch its address into the grant register, go to ISSUE.
//   - o_SD_ADDR = base + zero-extended address; o_SD_RD=1 from the cycle after the grant.
// - FSM ISSUE
//   - Hold o_SD_RD and o_SD_ADDR stable until i_SD_ACK.
//   - On i_SD_ACK: o_SD_RD=0 same edge, go to WAIT.
// - FSM WAIT
//   - On i_SD_DVALID: write i_SD_DATA into the granted port's data and cache entry.
//   - Cache addr = latched grant address (not the live bus); valid=1; go to IDLE.
//   - Back-to-back grant is possible on the next cycle.
// - ACK and DVALID in the same cycle: legal; treat as ISSUE→IDLE with the fill applied.
// - Arbitration
//   - Both miss: OBJ wins unless run==OBJ_MAXRUN, then CPU wins.
//   - run increments on each OBJ grant while the CPU misses; clears on a CPU grant or when the CPU has no miss.
// - Requester abandons (RQ_n=1 or address change) mid-transaction:
//   - Transaction completes; cache filled with the latched address.
//   - RDY is not asserted unless a subsequent hit occurs.
// - o_*_DATA changes only on a fill of that port; never on the other port's fill.
// - Address wrap: base + addr truncates to SD_AW bits; no range check.
// - Async reset mid-transaction: immediate return to reset state.
//   - The SDRAM controller shares this reset, so no stale DVALID is tracked.
// - DVALID in IDLE/ISSUE (spurious): ignored.
// - Latency, miss: grant +1 → RD; ack; DVALID +1 → data; RDY +1 after that.
// - Latency, hit: RDY 1 cycle after the address is presented.
// STRUCTURE
// - Package sdrq_pkg
//   - typedef enum {SDRQ_IDLE, SDRQ_ISSUE, SDRQ_WAIT} sdrq_state_t
//   - localparams SDRQ_ID_CPU=0, SDRQ_ID_OBJ=1
// - Sub-module sdrq_port, instantiated twice
//   - Holds cached addr/valid/data, miss/hit compare and registered RDY.
//   - Fill port: fill_en, fill_addr, fill_data.
// - Top: FSM, arbiter, run counter, grant/address register, SDRAM outputs.
// TESTING
// - Reset then CPU RQ_n=0 addr 17'h00100, SDRAM acks 2 cycles later, DVALID data 8'hA5 at +3
//   - One SD read at 24'h000100; o_CPU_DATA=8'hA5; o_CPU_RDY=1 one cycle after the fill.
// - Repeat CPU addr 17'h00100 after RQ_n toggles → zero SDRAM reads; RDY=1 within 1 cycle.
// - CPU and OBJ both miss continuously; OBJ addresses change every fill
//   - Grant order OBJ,OBJ,OBJ,OBJ,CPU,OBJ...; first OBJ read at 24'h020000+addr.
// - ACK and DVALID in the same cycle, data 8'h3C → fill applied; FSM back to IDLE next cycle.
// - OBJ changes addr 17'h00010→17'h00011 while in WAIT
//   - Fill cached for 17'h00010; o_OBJ_RDY stays 0; a new read is issued for 17'h00011.
// - Assert reset during WAIT → all outputs 0 at once; post-reset DVALID pulse ignored; caches invalid.

Source files
------------

// File: rtl/sdrq_pkg.sv
// Shared types and constants for the SDRAM request arbiter.
package sdrq_pkg;

  typedef enum logic [1:0] {
    SDRQ_IDLE  = 2'd0,
    SDRQ_ISSUE = 2'd1,
    SDRQ_WAIT  = 2'd2
  } sdrq_state_t;

  localparam logic SDRQ_ID_CPU = 1'b0;
  localparam logic SDRQ_ID_OBJ = 1'b1;

endpackage

// File: rtl/sdram_rq_arbiter_if.sv
// Requester and SDRAM read-port bundle; slave = arbiter view, master = environment view.
interface sdram_rq_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int SD_AW  = 24
);
  logic [ADDR_W-1:0] i_CPU_ADDR;
  logic              i_CPU_RQ_n;
  logic [7:0]        o_CPU_DATA;
  logic              o_CPU_RDY;

  logic [ADDR_W-1:0] i_OBJ_ADDR;
  logic              i_OBJ_RQ_n;
  logic [7:0]        o_OBJ_DATA;
  logic              o_OBJ_RDY;

  logic [SD_AW-1:0]  o_SD_ADDR;
  logic              o_SD_RD;
  logic              i_SD_ACK;
  logic              i_SD_DVALID;
  logic [7:0]        i_SD_DATA;

  modport slave (
    input  i_CPU_ADDR, i_CPU_RQ_n, i_OBJ_ADDR, i_OBJ_RQ_n,
    input  i_SD_ACK, i_SD_DVALID, i_SD_DATA,
    output o_CPU_DATA, o_CPU_RDY, o_OBJ_DATA, o_OBJ_RDY,
    output o_SD_ADDR, o_SD_RD
  );

  modport master (
    output i_CPU_ADDR, i_CPU_RQ_n, i_OBJ_ADDR, i_OBJ_RQ_n,
    output i_SD_ACK, i_SD_DVALID, i_SD_DATA,
    input  o_CPU_DATA, o_CPU_RDY, o_OBJ_DATA, o_OBJ_RDY,
    input  o_SD_ADDR, o_SD_RD
  );
endinterface

// File: rtl/sdrq_port.sv
// One-entry hit cache for a single requester: cached addr/data, miss/hit compare, registered RDY.
module sdrq_port #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rq_n,
  input  logic              fill_en,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [7:0]        fill_data,
  output logic              miss,
  output logic [7:0]        data,
  output logic              rdy
);

  logic [ADDR_W-1:0] cache_addr;
  logic              valid;
  logic              match;

  assign match = valid && (addr == cache_addr);
  assign miss  = !rq_n && !match;

  // RDY follows the pre-fill compare, so it trails a fill by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_addr <= '0;
      valid      <= 1'b0;
      data       <= '0;
      rdy        <= 1'b0;
    end else begin
      rdy <= !rq_n && match;
      if (fill_en) begin
        cache_addr <= fill_addr;
        valid      <= 1'b1;
        data       <= fill_data;
      end
    end
  end

endmodule

// File: rtl/sdram_rq_arbiter.sv
// Shares one SDRAM read port between MAINCPU program ROM and OBJROM with per-port hit caches.
//   state       | meaning
//   SDRQ_IDLE   | no read outstanding, arbitrate between misses
//   SDRQ_ISSUE  | o_SD_RD held until the controller acks
//   SDRQ_WAIT   | command accepted, waiting for the data strobe
module sdram_rq_arbiter
  import sdrq_pkg::*;
#(
  parameter int               ADDR_W     = 17,
  parameter int               SD_AW      = 24,
  parameter logic [SD_AW-1:0] CPU_BASE   = 24'h000000,
  parameter logic [SD_AW-1:0] OBJ_BASE   = 24'h020000,
  parameter int               OBJ_MAXRUN = 4
) (
  input  logic                i_EMU_MCLK,
  input  logic                i_EMU_INITRST_n,
  sdram_rq_arbiter_if.slave   bus
);

  sdrq_state_t       state;
  logic              grant_id;
  logic [ADDR_W-1:0] grant_addr;
  logic [3:0]        run;
  logic [SD_AW-1:0]  sd_addr;
  logic              sd_rd;

  logic              cpu_miss, obj_miss;
  logic              cpu_rdy, obj_rdy;
  logic [7:0]        cpu_data, obj_data;
  logic              fill, fill_cpu, fill_obj;
  logic              pick_obj;
  logic [ADDR_W-1:0] pick_addr;
  logic [SD_AW-1:0]  pick_base;

  // ACK and DVALID together in ISSUE completes the transaction in one step.
  assign fill     = (state == SDRQ_WAIT && bus.i_SD_DVALID) ||
                    (state == SDRQ_ISSUE && bus.i_SD_ACK && bus.i_SD_DVALID);
  assign fill_cpu = fill && (grant_id == SDRQ_ID_CPU);
  assign fill_obj = fill && (grant_id == SDRQ_ID_OBJ);

  assign pick_obj  = obj_miss && !(cpu_miss && run == 4'(OBJ_MAXRUN));
  assign pick_addr = pick_obj ? bus.i_OBJ_ADDR : bus.i_CPU_ADDR;
  assign pick_base = pick_obj ? OBJ_BASE : CPU_BASE;

  sdrq_port #(.ADDR_W(ADDR_W)) u_cpu (
    .clk       (i_EMU_MCLK),
    .rst_n     (i_EMU_INITRST_n),
    .addr      (bus.i_CPU_ADDR),
    .rq_n      (bus.i_CPU_RQ_n),
    .fill_en   (fill_cpu),
    .fill_addr (grant_addr),
    .fill_data (bus.i_SD_DATA),
    .miss      (cpu_miss),
    .data      (cpu_data),
    .rdy       (cpu_rdy)
  );

  sdrq_port #(.ADDR_W(ADDR_W)) u_obj (
    .clk       (i_EMU_MCLK),
    .rst_n     (i_EMU_INITRST_n),
    .addr      (bus.i_OBJ_ADDR),
    .rq_n      (bus.i_OBJ_RQ_n),
    .fill_en   (fill_obj),
    .fill_addr (grant_addr),
    .fill_data (bus.i_SD_DATA),
    .miss      (obj_miss),
    .data      (obj_data),
    .rdy       (obj_rdy)
  );

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) begin
      state      <= SDRQ_IDLE;
      grant_id   <= SDRQ_ID_CPU;
      grant_addr <= '0;
      run        <= '0;
      sd_addr    <= '0;
      sd_rd      <= 1'b0;
    end else begin
      if (!cpu_miss) run <= '0;
      case (state)
        SDRQ_IDLE: begin
          if (cpu_miss || obj_miss) begin
            grant_id   <= pick_obj ? SDRQ_ID_OBJ : SDRQ_ID_CPU;
            grant_addr <= pick_addr;
            sd_addr    <= pick_base + SD_AW'(pick_addr);
            sd_rd      <= 1'b1;
            state      <= SDRQ_ISSUE;
            if (!pick_obj)    run <= '0;
            else if (cpu_miss) run <= run + 4'd1;
          end
        end
        SDRQ_ISSUE: begin
          if (bus.i_SD_ACK) begin
            sd_rd <= 1'b0;
            state <= bus.i_SD_DVALID ? SDRQ_IDLE : SDRQ_WAIT;
          end
        end
        SDRQ_WAIT: begin
          if (bus.i_SD_DVALID) state <= SDRQ_IDLE;
        end
        default: state <= SDRQ_IDLE;
      endcase
    end
  end

  assign bus.o_SD_ADDR  = sd_addr;
  assign bus.o_SD_RD    = sd_rd;
  assign bus.o_CPU_DATA = cpu_data;
  assign bus.o_CPU_RDY  = cpu_rdy;
  assign bus.o_OBJ_DATA = obj_data;
  assign bus.o_OBJ_RDY  = obj_rdy;

endmodule

// File: tb/tb_sdram_rq_arbiter.sv
// Directed bench for sdram_rq_arbiter with a scoreboard of expected SDRAM reads and fills.
module tb_sdram_rq_arbiter;
  import sdrq_pkg::*;

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  data;
    logic        port;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cmds        = 0;
  logic [7:0] last_cpu = 8'h00;
  logic [7:0] last_obj = 8'h00;
  exp_t sb[$];

  sdram_rq_arbiter_if bus ();

  sdram_rq_arbiter dut (
    .i_EMU_MCLK      (clk),
    .i_EMU_INITRST_n (rst_n),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.o_SD_RD === 1'b1 && bus.i_SD_ACK === 1'b1) cmds++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [23:0] a, input logic [7:0] d, input logic p);
    exp_t e;
    e.addr = a; e.data = d; e.port = p;
    sb.push_back(e);
  endtask

  task automatic wait_rd(output exp_t e);
    int n = 0;
    e.addr = '0; e.data = '0; e.port = 1'b0;
    while (bus.o_SD_RD !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rd_issued", 32'(bus.o_SD_RD), 32'd1);
    if (sb.size() != 0) e = sb.pop_front();
    chk("sd_addr", 32'(bus.o_SD_ADDR), 32'(e.addr));
  endtask

  task automatic do_ack(input exp_t e, input int ack_wait, input bit same);
    repeat (ack_wait) begin
      @(negedge clk);
      chk("rd_hold", 32'(bus.o_SD_RD), 32'd1);
      chk("addr_hold", 32'(bus.o_SD_ADDR), 32'(e.addr));
    end
    bus.i_SD_ACK = 1'b1;
    if (same) begin
      bus.i_SD_DVALID = 1'b1;
      bus.i_SD_DATA   = e.data;
    end
    @(negedge clk);
    bus.i_SD_ACK    = 1'b0;
    bus.i_SD_DVALID = 1'b0;
    chk("rd_drop", 32'(bus.o_SD_RD), 32'd0);
  endtask

  task automatic do_dv(input exp_t e, input int dv_wait);
    repeat (dv_wait - 1) @(negedge clk);
    bus.i_SD_DVALID = 1'b1;
    bus.i_SD_DATA   = e.data;
    @(negedge clk);
    bus.i_SD_DVALID = 1'b0;
    bus.i_SD_DATA   = 8'h00;
  endtask

  task automatic chk_fill(input exp_t e);
    if (e.port == SDRQ_ID_CPU) begin
      chk("cpu_data", 32'(bus.o_CPU_DATA), 32'(e.data));
      chk("obj_data_kept", 32'(bus.o_OBJ_DATA), 32'(last_obj));
      last_cpu = e.data;
    end else begin
      chk("obj_data", 32'(bus.o_OBJ_DATA), 32'(e.data));
      chk("cpu_data_kept", 32'(bus.o_CPU_DATA), 32'(last_cpu));
      last_obj = e.data;
    end
  endtask

  task automatic serve(input int ack_wait, input int dv_wait);
    exp_t e;
    wait_rd(e);
    do_ack(e, ack_wait, dv_wait == 0);
    if (dv_wait > 0) do_dv(e, dv_wait);
    chk_fill(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cpu_data"}, 32'(bus.o_CPU_DATA), 32'd0);
    chk({tag, "_cpu_rdy"},  32'(bus.o_CPU_RDY),  32'd0);
    chk({tag, "_obj_data"}, 32'(bus.o_OBJ_DATA), 32'd0);
    chk({tag, "_obj_rdy"},  32'(bus.o_OBJ_RDY),  32'd0);
    chk({tag, "_sd_addr"},  32'(bus.o_SD_ADDR),  32'd0);
    chk({tag, "_sd_rd"},    32'(bus.o_SD_RD),    32'd0);
  endtask

  initial begin
    exp_t e;
    bus.i_CPU_ADDR  = '0; bus.i_CPU_RQ_n = 1'b1;
    bus.i_OBJ_ADDR  = '0; bus.i_OBJ_RQ_n = 1'b1;
    bus.i_SD_ACK    = 1'b0; bus.i_SD_DVALID = 1'b0; bus.i_SD_DATA = 8'h00;

    // reset state
    repeat (2) @(negedge clk);
    chk_all_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // single CPU miss
    bus.i_CPU_ADDR = 17'h00100; bus.i_CPU_RQ_n = 1'b0;
    push(24'h000100, 8'hA5, SDRQ_ID_CPU);
    serve(2, 3);
    chk("cpu_rdy_at_fill", 32'(bus.o_CPU_RDY), 32'd0);
    @(negedge clk);
    chk("cpu_rdy_after_fill", 32'(bus.o_CPU_RDY), 32'd1);
    chk("cmds_t1", 32'(cmds), 32'd1);

    // repeat access hits without touching SDRAM
    bus.i_CPU_RQ_n = 1'b1;
    @(negedge clk);
    chk("cpu_rdy_release", 32'(bus.o_CPU_RDY), 32'd0);
    bus.i_CPU_RQ_n = 1'b0;
    @(negedge clk);
    chk("cpu_rdy_hit", 32'(bus.o_CPU_RDY), 32'd1);
    chk("rd_idle_hit", 32'(bus.o_SD_RD), 32'd0);

    // spurious DVALID while idle
    bus.i_SD_DVALID = 1'b1; bus.i_SD_DATA = 8'hFF;
    @(negedge clk);
    bus.i_SD_DVALID = 1'b0; bus.i_SD_DATA = 8'h00;
    repeat (2) @(negedge clk);
    chk("spurious_cpu_data", 32'(bus.o_CPU_DATA), 32'hA5);
    chk("spurious_obj_data", 32'(bus.o_OBJ_DATA), 32'h00);
    chk("cmds_t2", 32'(cmds), 32'd1);

    // arbitration: both miss, OBJ address changes every fill
    bus.i_CPU_ADDR = 17'h00200;
    bus.i_OBJ_ADDR = 17'h01000; bus.i_OBJ_RQ_n = 1'b0;
    begin
      int k = 0;
      for (int g = 0; g < 6; g++) begin
        if (g == 4) push(24'h000200, 8'h50 + 8'(g), SDRQ_ID_CPU);
        else        push(24'h020000 + 24'(17'h01000 + 17'(k)), 8'h50 + 8'(g), SDRQ_ID_OBJ);
        serve(1, 1);
        if (g == 4) bus.i_CPU_ADDR = 17'h00300;
        else begin
          k++;
          bus.i_OBJ_ADDR = 17'h01000 + 17'(k);
        end
      end
    end
    bus.i_CPU_RQ_n = 1'b1; bus.i_OBJ_RQ_n = 1'b1;
    @(negedge clk);
    chk("rd_idle_t3", 32'(bus.o_SD_RD), 32'd0);
    chk("cmds_t3", 32'(cmds), 32'd7);

    // ACK and DVALID in the same cycle
    bus.i_CPU_ADDR = 17'h00400; bus.i_CPU_RQ_n = 1'b0;
    push(24'h000400, 8'h3C, SDRQ_ID_CPU);
    serve(1, 0);
    chk("idle_after_same", 32'(dut.state), 32'(SDRQ_IDLE));
    @(negedge clk);
    chk("cpu_rdy_same", 32'(bus.o_CPU_RDY), 32'd1);
    bus.i_CPU_RQ_n = 1'b1;

    // OBJ abandons its address while the read is outstanding
    bus.i_OBJ_ADDR = 17'h00010; bus.i_OBJ_RQ_n = 1'b0;
    push(24'h020010, 8'h77, SDRQ_ID_OBJ);
    wait_rd(e);
    do_ack(e, 1, 1'b0);
    bus.i_OBJ_ADDR = 17'h00011;
    push(24'h020011, 8'h88, SDRQ_ID_OBJ);
    do_dv(e, 2);
    chk_fill(e);
    chk("obj_rdy_abandon", 32'(bus.o_OBJ_RDY), 32'd0);
    wait_rd(e);
    chk("obj_rdy_abandon2", 32'(bus.o_OBJ_RDY), 32'd0);
    do_ack(e, 0, 1'b0);

    // reset while waiting for data
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    bus.i_OBJ_RQ_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    last_cpu = 8'h00; last_obj = 8'h00;
    @(negedge clk);
    bus.i_SD_DVALID = 1'b1; bus.i_SD_DATA = 8'h88;
    @(negedge clk);
    bus.i_SD_DVALID = 1'b0; bus.i_SD_DATA = 8'h00;
    @(negedge clk);
    chk_all_zero("postrst");

    // previously cached address must miss again
    bus.i_OBJ_ADDR = 17'h00010; bus.i_OBJ_RQ_n = 1'b0;
    push(24'h020010, 8'h99, SDRQ_ID_OBJ);
    serve(1, 1);
    @(negedge clk);
    chk("obj_rdy_refill", 32'(bus.o_OBJ_RDY), 32'd1);
    chk("cmds_total", 32'(cmds), 32'd11);
    bus.i_OBJ_RQ_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
